dadda_mac_pipe: RTL

- Parametrised, pipelined successor to the 8x8 Dadda multiply-add datapath.
- Computes res = a*b + addend, with WIDTH-bit operands and a 2*WIDTH+1-bit result.
- The addend is either the external m operand or an internal running accumulator.
- Adds valid/ready handshaking and back-pressure; sits between an operand source and a result consumer in the arithmetic datapath.

---
 rtl/dadda_mac_pipe_if.sv | 37 +++
 rtl/dadda_mac_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_pipe_if.sv
// Operand/result handshake bundle for dadda_mac_pipe.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_ready   operand handshake
//   a, b                 WIDTH-bit multiplicand / multiplier
//   m                    2*WIDTH-bit external addend
//   acc_en, acc_clr      accumulator addend select / clear
//   out_valid, out_ready result handshake
//   res, acc             2*WIDTH+1-bit result and current accumulator
// Modports: slave = the datapath, master = the operand source / result consumer.
interface dadda_mac_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   m;
    logic                 acc_en;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH:0]     res;
    logic [2*WIDTH:0]     acc;

    modport slave (
        input  in_valid, a, b, m, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, res, acc
    );

    modport master (
        output in_valid, a, b, m, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, res, acc
    );
endinterface

// File: rtl/dadda_mac_pipe.sv
// Pipelined multiply-add: res = a*b + addend (m, running accumulator, or 0), mod 2^(2*WIDTH+1).
// Latency: STAGES cycles from acceptance to out_valid, one op per cycle when not stalled.
// Backpressure: global stall; every stage holds while out_valid && !out_ready, in_ready = advance.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears stage valids, res and acc
//   bus    dadda_mac_pipe_if.slave (operand/result handshake, res, acc)
// Build option: define DADDA_MAC_SIGNED_EN for two's complement a, b, m (m sign-extended);
// default build is fully unsigned with m zero-extended.
//
// Structure: stage 0 (combinational) builds the partial-product rows and compresses them
// with layers of 3:2 counters down to a carry-save sum/carry pair. Stages 1..STAGES-1 carry
// that pair forward; the final carry-propagate add with the selected addend happens on load
// of the output register (stage STAGES). With STAGES=1 everything lands in the one register.
module dadda_mac_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    dadda_mac_pipe_if.slave  bus
);
    localparam int RW = 2*WIDTH + 1;
`ifdef DADDA_MAC_SIGNED_EN
    // Extra row carries the +1 of the negated sign row (Baugh-Wooley style two's complement).
    localparam int NR = WIDTH + 1;
`else
    localparam int NR = WIDTH;
`endif
    localparam int IW = $clog2(NR);

    typedef struct packed {
        logic          vld;
        logic          acc_en;
        logic          acc_clr;
        logic [RW-1:0] m_ext;
        logic [RW-1:0] sum;
        logic [RW-1:0] car;
    } stage_t;

    logic          advance;
    logic          out_xfer;
    logic          out_vld_q;
    logic          out_acc_q;
    logic [RW-1:0] res_q;
    logic [RW-1:0] acc_q;
    logic [RW-1:0] acc_src;
    logic [RW-1:0] addend;
    logic [RW-1:0] res_d;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] pp [NR];
    stage_t        s0;
    stage_t        fin_in;

    assign advance  = !out_vld_q || bus.out_ready;
    assign out_xfer = out_vld_q && bus.out_ready;

    // ------------------------------------------------------------------
    // Partial products
    // ------------------------------------------------------------------
`ifdef DADDA_MAC_SIGNED_EN
    assign a_ext = {{(RW-WIDTH){bus.a[WIDTH-1]}}, bus.a};

    // b's MSB has weight -2^(WIDTH-1): that row is negated as ~row + 1, the +1 in its own row.
    always_comb begin : pp_gen
        for (int r = 0; r < NR; r++) pp[r] = '0;
        for (int i = 0; i < WIDTH-1; i++) begin
            pp[i] = bus.b[i] ? (a_ext << i) : '0;
        end
        pp[WIDTH-1] = bus.b[WIDTH-1] ? ~(a_ext << (WIDTH-1)) : '0;
        pp[WIDTH]   = RW'(bus.b[WIDTH-1]);
    end
`else
    assign a_ext = {{(RW-WIDTH){1'b0}}, bus.a};

    always_comb begin : pp_gen
        for (int r = 0; r < NR; r++) pp[r] = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = bus.b[i] ? (a_ext << i) : '0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Reduction tree: each layer groups rows in threes and replaces each
    // group by a 3:2 counter output (sum row, carry row shifted left);
    // leftover rows pass through. Layers repeat until two rows remain.
    // Bits carried beyond RW are dropped, which is the mod 2^RW wrap.
    // ------------------------------------------------------------------
    always_comb begin : csa_tree
        logic [RW-1:0] cur [NR];
        logic [RW-1:0] nxt [NR];
        int            n;
        int            m;

        for (int r = 0; r < NR; r++) begin
            cur[r] = pp[r];
            nxt[r] = '0;
        end
        n = NR;
        m = 0;

        for (int lvl = 0; lvl < NR; lvl++) begin
            if (n > 2) begin
                for (int r = 0; r < NR; r++) nxt[r] = '0;
                m = 0;
                for (int g = 0; g < NR/3; g++) begin
                    if (g < n/3) begin
                        nxt[IW'(m)]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                        nxt[IW'(m+1)] = ((cur[3*g]   & cur[3*g+1]) |
                                         (cur[3*g]   & cur[3*g+2]) |
                                         (cur[3*g+1] & cur[3*g+2])) << 1;
                        m = m + 2;
                    end
                end
                for (int r = 0; r < NR; r++) begin
                    if (r >= 3*(n/3) && r < n) begin
                        nxt[IW'(m)] = cur[r];
                        m = m + 1;
                    end
                end
                for (int r = 0; r < NR; r++) cur[r] = nxt[r];
                n = m;
            end
        end

        s0         = '0;
        s0.vld     = bus.in_valid;
        s0.acc_en  = bus.acc_en;
        s0.acc_clr = bus.acc_clr;
`ifdef DADDA_MAC_SIGNED_EN
        s0.m_ext   = {bus.m[2*WIDTH-1], bus.m};
`else
        s0.m_ext   = {1'b0, bus.m};
`endif
        s0.sum     = cur[0];
        s0.car     = cur[1];
    end

    // ------------------------------------------------------------------
    // Carry-save pipeline stages 1..STAGES-1 (global stall on !advance)
    // ------------------------------------------------------------------
    generate
        if (STAGES == 1) begin : g_single
            assign fin_in = s0;
        end else begin : g_multi
            stage_t pipe_q [1:STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i < STAGES; i++) pipe_q[i] <= '0;
                end else if (advance) begin
                    pipe_q[1] <= s0;
                    for (int i = 2; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign fin_in = pipe_q[STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Final add into the output register
    // ------------------------------------------------------------------
    // When the op leaving this cycle writes the accumulator, the op loading
    // behind it must see that new value, not the stale acc_q.
    assign acc_src = (out_xfer && out_acc_q) ? res_q : acc_q;

    always_comb begin
        addend = fin_in.m_ext;
        if (fin_in.acc_en) begin
            addend = fin_in.acc_clr ? '0 : acc_src;
        end
    end

    assign res_d = fin_in.sum + fin_in.car + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_acc_q <= 1'b0;
            res_q     <= '0;
            acc_q     <= '0;
        end else begin
            if (advance) begin
                out_vld_q <= fin_in.vld;
                // res only changes when a real op lands, so it holds the last result across bubbles.
                if (fin_in.vld) begin
                    res_q     <= res_d;
                    out_acc_q <= fin_in.acc_en;
                end
            end
            if (out_xfer && out_acc_q) begin
                acc_q <= res_q;
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_vld_q;
    assign bus.res       = res_q;
    assign bus.acc       = acc_q;
endmodule
